// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe win checker.
// Cell codes, FSM states and the line-to-cell coordinate table.
package tictactoe_pkg;

  localparam logic [1:0] EMPTY   = 2'b00;
  localparam logic [1:0] P1      = 2'b01;
  localparam logic [1:0] P2      = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_e;

  typedef logic [3:1][3:1][1:0] board_t;

  // Each cell entry is 8'hRC (row nibble, col nibble).
  // Entry layout per line: {cell2, cell1, cell0}.
  localparam logic [7:0][2:0][7:0] LINE_TAB = {
    24'h31_22_13,  // 7: anti-diagonal
    24'h33_22_11,  // 6: diagonal
    24'h33_23_13,  // 5: col 3
    24'h32_22_12,  // 4: col 2
    24'h31_21_11,  // 3: col 1
    24'h33_32_31,  // 2: row 3
    24'h23_22_21,  // 1: row 2
    24'h13_12_11   // 0: row 1
  };

  function automatic logic [1:0] cell_at(
    input board_t     b,
    input logic [2:0] idx,
    input logic [1:0] k
  );
    logic [7:0] rc;
    rc = LINE_TAB[idx][k];
    return b[rc[5:4]][rc[1:0]];
  endfunction

  function automatic logic cell_ok(input logic [1:0] c);
    return (c == P1) || (c == P2);
  endfunction

  function automatic logic board_full(input board_t b);
    return cell_ok(b[1][1]) & cell_ok(b[1][2]) & cell_ok(b[1][3])
         & cell_ok(b[2][1]) & cell_ok(b[2][2]) & cell_ok(b[2][3])
         & cell_ok(b[3][1]) & cell_ok(b[3][2]) & cell_ok(b[3][3]);
  endfunction

endpackage

// File: rtl/tictactoe_line_eval.sv
// Combinational evaluation of one three-cell line.
// Only a line of three equal player codes counts as won.
module tictactoe_line_eval
  import tictactoe_pkg::*;
(
  input  logic [1:0] cell0_i,
  input  logic [1:0] cell1_i,
  input  logic [1:0] cell2_i,
  output logic       won_o,
  output logic [1:0] owner_o
);

  // Equal cells holding a player code win; EMPTY/INVALID never do.
  always_comb begin
    won_o   = (cell0_i == cell1_i)
            && (cell1_i == cell2_i)
            && cell_ok(cell0_i);
    owner_o = won_o ? cell0_i : EMPTY;
  end

endmodule

// File: rtl/tictactoe_win_checker.sv
// Sequential tic-tac-toe judge: scans one line per clock
// over a snapshot of the board, then reports the result.
module tictactoe_win_checker
  import tictactoe_pkg::*;
#(
  parameter logic LATCH_RESULT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 check_start,
  input  logic [3:1][3:1][1:0] board,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           winner,
  output logic [2:0]           win_line,
  output logic                 draw
);

  state_e     state_q, state_d;
  board_t     snap_q;
  logic [2:0] cnt_q;
  logic       last_q;
  logic       found_q;
  logic [1:0] fown_q;
  logic [2:0] fidx_q;
  logic [1:0] winner_q;
  logic [2:0] line_q;
  logic       draw_q;

  logic [1:0] c0, c1, c2;
  logic       won;
  logic [1:0] owner;

  // Route the counter-selected line of the snapshot to the evaluator.
  always_comb begin
    c0 = cell_at(snap_q, cnt_q, 2'd0);
    c1 = cell_at(snap_q, cnt_q, 2'd1);
    c2 = cell_at(snap_q, cnt_q, 2'd2);
  end

  tictactoe_line_eval u_eval (
    .cell0_i (c0),
    .cell1_i (c1),
    .cell2_i (c2),
    .won_o   (won),
    .owner_o (owner)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; the cycle after line 7 loads the outputs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (check_start) state_d = SCAN;
      SCAN:    if (last_q) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot, line counter, first-win tracking and results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q   <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      found_q  <= 1'b0;
      fown_q   <= EMPTY;
      fidx_q   <= '0;
      winner_q <= EMPTY;
      line_q   <= '0;
      draw_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (check_start) begin
            snap_q   <= board;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            found_q  <= 1'b0;
            fown_q   <= EMPTY;
            fidx_q   <= '0;
            winner_q <= EMPTY;
            line_q   <= '0;
            draw_q   <= 1'b0;
          end
        end
        SCAN: begin
          if (!last_q) begin
            if (won && !found_q) begin
              found_q <= 1'b1;
              fown_q  <= owner;
              fidx_q  <= cnt_q;
            end
            if (cnt_q == 3'd7) last_q <= 1'b1;
            else               cnt_q  <= cnt_q + 3'd1;
          end else begin
            winner_q <= fown_q;
            line_q   <= fidx_q;
            draw_q   <= !found_q && board_full(snap_q);
          end
        end
        REPORT: begin
          if (!LATCH_RESULT) begin
            winner_q <= EMPTY;
            line_q   <= '0;
            draw_q   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status decodes straight from state so reset clears them at once.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == REPORT);
    winner   = winner_q;
    win_line = line_q;
    draw     = draw_q;
  end

endmodule

// File: doc/tictactoe_win_checker.md
TICTACTOE_WIN_CHECKER -- requirements
Module: tictactoe_win_checker

Interface
REQ-001 SHALL have parameter LATCH_RESULT, default 1, meaning: 1 = hold results until next accepted start; 0 = clear results after the done cycle.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (low = reset).
REQ-004 SHALL have port check_start  input  1  request to evaluate the board, sampled on clk.
REQ-005 SHALL have port board  input  2x[3:1][3:1]  cell codes: 00 empty, 01 player1, 10 player2, 11 invalid.
REQ-006 SHALL have port busy  output  1  evaluation in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-008 SHALL have port winner  output  2  00 none, 01 player1, 10 player2.
REQ-009 SHALL have port win_line  output  3  index of the winning line, 0-7; 0 when there is no winner.
REQ-010 SHALL have port draw  output  1  board full with no winner.

Function
REQ-011 Line index mapping SHALL be: 0-2 = rows 1-3; 3-5 = cols 1-3; 6 = diag (1,1)(2,2)(3,3); 7 = anti-diag (1,3)(2,2)(3,1).
REQ-012 The FSM SHALL have states IDLE, SCAN, REPORT; reset SHALL place it in IDLE.
REQ-013 In IDLE, check_start=1 at a clk edge SHALL snapshot board into an internal register, clear the line counter to 0, and enter SCAN.
REQ-014 In SCAN, each clk edge SHALL evaluate one line of the snapshot (counter 0..7), so that all 8 lines are evaluated on 8 consecutive edges.
REQ-015 A line SHALL count as won only if all three cells are equal and equal to 01 or 10; a cell of 00 or 11 SHALL never contribute to a win.
REQ-016 Only the first won line (lowest index) SHALL be recorded; later wins in the same scan SHALL be ignored, including an illegal board where both players have a line.
REQ-017 After line 7 is evaluated, the FSM SHALL enter REPORT; in REPORT, done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be fixed: with start accepted at edge k, done SHALL be high during the cycle after edge k+9.
REQ-019 busy SHALL be 1 in SCAN and REPORT and 0 in IDLE.
REQ-020 draw SHALL be 1 only if no line is won and all 9 snapshot cells are 01 or 10.
REQ-021 winner, win_line and draw SHALL update at the edge entering REPORT.
REQ-022 If LATCH_RESULT=1, results SHALL hold until the next accepted start; if 0, results SHALL return to 0 on the edge leaving REPORT.
REQ-023 check_start while busy SHALL be ignored, not queued.
REQ-024 Changes to board after the snapshot SHALL NOT affect the current scan.
REQ-025 The counter SHALL NOT wrap past 7; reaching 7 SHALL force the transition to REPORT.

Reset
REQ-026 reset=0 SHALL immediately, regardless of clk, force: state IDLE, busy=0, done=0, winner=00, win_line=0, draw=0, counter=0, snapshot all 00.
REQ-027 reset asserted mid-SCAN SHALL abort the scan with no done pulse.
REQ-028 After reset deasserts, check_start SHALL be accepted on the first clk edge.

Structure
REQ-029 Shared package tictactoe_pkg SHALL hold the cell code constants (EMPTY, P1, P2, INVALID), the FSM state enum, and the 8-entry line-to-cell coordinate table.
REQ-030 A combinational sub-module tictactoe_line_eval SHALL take three cells and return won (1 bit) and owner (2 bits); it SHALL be instantiated once and fed by the counter-selected line.

Verification
REQ-031 Row win: row 2 = 01,01,01, all other cells 00, start pulse -> done at cycle k+10, winner=01, win_line=1, draw=0.
REQ-032 Anti-diagonal win for P2: (1,3),(2,2),(3,1) = 10, rest mixed without a line -> winner=10, win_line=7.
REQ-033 Draw: full board 01,10,01 / 01,10,10 / 10,01,01 -> winner=00, draw=1, win_line=0.
REQ-034 Illegal board: row 1 all 01 and row 3 all 10 -> winner=01, win_line=0; a second start during busy causes no extra done.
REQ-035 Cells 11 in column 3 plus the board changing mid-scan -> no win attributed to 11, result matches the snapshot.
REQ-036 reset=0 at the 4th SCAN cycle -> outputs 0 asynchronously, no done; a fresh start after release completes normally.
